par2ser: RTL and testbench
==========================

Name: par2ser

Overview:
Parallel-to-serial transmitter, the sending end of the 1-bit serial link whose receiver shifts bits in LSB-side (first bit lands in MSB). Accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per enabled cycle, with a bit-valid strobe. A one-word holding buffer lets back-to-back words stream with no idle cycle between them. The serial output drives the receiver's rx_data/rx_val pair directly.

Parameters:
WIDTH, 32, word width in bits (>=2); bit counter width is $clog2(WIDTH)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
in_data  input  WIDTH  parallel word to send
in_val  input  1  in_data valid
in_rdy  output  1  block can accept a word this cycle
tx_en  input  1  downstream enable; bit advances only when high
tx_data  output  1  serial bit, MSB of current word first
tx_val  output  1  tx_data holds a valid bit
tx_last  output  1  high while tx_data is bit 0 of the current word
busy  output  1  shifter or holding buffer occupied

Behaviour:
- Reset (rst low, async): state IDLE, shift_reg=0, buf empty, bit_cnt=0; tx_data=0, tx_val=0, tx_last=0, busy=0, in_rdy=0 while rst low, in_rdy=1 from first cycle after release.
- Storage: shift_reg[WIDTH-1:0], bit_cnt, hold_buf[WIDTH-1:0] + buf_full flag. All outputs derived from registers only (no in->out combinational path except none; in_rdy = !buf_full).
- Accept: word taken on rising edge where in_val && in_rdy. in_data must be ignored when in_val low.
- States: IDLE (shifter empty), SHIFT (shifter holds word).
- IDLE + accept: word loads directly into shift_reg (bypass buffer), bit_cnt=0, -> SHIFT. First bit on tx_data the cycle after the handshake (latency 1).
- SHIFT: tx_val=1, tx_data=shift_reg[WIDTH-1], tx_last=(bit_cnt==WIDTH-1). On edge with tx_en=1: shift_reg<<1, bit_cnt+1. tx_en=0: everything holds (tx_val stays 1, same bit).
- SHIFT + accept: word goes to hold_buf, buf_full=1, in_rdy drops next cycle.
- End of word (tx_en=1 and bit_cnt==WIDTH-1): if buf_full -> load hold_buf into shift_reg, bit_cnt=0, buf_full=0, stay SHIFT (no gap). Else if accept in same cycle -> load in_data straight into shift_reg, stay SHIFT. Else -> IDLE, tx_val=0 next cycle.
- Simultaneous end-of-word + accept while buf_full: impossible (in_rdy=0).
- Simultaneous end-of-word + accept with buf empty: in_data loads into shifter, buffer stays empty.
- bit_cnt wraps to 0 only via reload; never free-runs in IDLE.
- busy = (state==SHIFT) || buf_full.
- Reset mid-word: partial word and buffered word discarded; no further tx_val until new accept.
- tx_en ignored in IDLE.

Test Plan:
- Single word: reset, accept 32'hA5A5_0F0F, tx_en=1 -> tx_val high 32 cycles starting cycle after handshake; bits 1010_0101_1010_0101_0000_1111_0000_1111; tx_last only on 32nd bit; then IDLE, busy=0.
- Back-to-back: in_val held high with 32'hFFFF_0000 then 32'h0000_FFFF -> 64 contiguous tx_val cycles, no gap; in_rdy low from cycle after second accept until first word's last bit shifts.
- Stall: send 32'h8000_0001, drop tx_en for 5 cycles at bit 10 -> tx_data/tx_val/bit position frozen, total 37 tx_val cycles, sequence unchanged.
- Buffer full: accept three words with tx_en=1 -> third in_val waits until in_rdy returns; words emerge in order, none lost or duplicated.
- Reset mid-word: pulse rst low at bit 17 of 32'h1234_5678 with a word buffered -> tx_val=0, busy=0, in_rdy=1 after release, no further bits emitted.
- Loopback: drive serdes receiver from tx_data/tx_val -> receiver word equals sent word after 32 bits, for 100 random words.

Source files
------------

// File: rtl/par2ser.sv
// par2ser: parallel-to-serial transmitter.
// Takes WIDTH-bit words over a valid/ready handshake and sends them MSB-first,
// one bit per tx_en cycle. A one-word holding buffer lets words stream
// back-to-back with no idle cycle between them.
module par2ser #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic             tx_en,
  output logic             tx_data,
  output logic             tx_val,
  output logic             tx_last,
  output logic             busy
);

  localparam int CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shiftReg_q, shiftReg_d;
  logic [CntW-1:0]  bitCnt_q, bitCnt_d;
  logic [WIDTH-1:0] holdBuf_q, holdBuf_d;
  logic             bufFull_q, bufFull_d;
  logic             rdyEn_q;

  logic accept;
  logic lastBit;
  logic wordDone;

  // A word is taken only on a real handshake; wordDone marks the edge that
  // shifts out bit 0 of the current word.
  assign accept   = in_val && in_rdy;
  assign lastBit  = (bitCnt_q == LastIdx);
  assign wordDone = (state_q == SHIFT) && tx_en && lastBit;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave SHIFT only when a word ends with nothing queued behind it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (wordDone && !bufFull_q && !accept) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: load, shift, reload from buffer or park a new word.
  always_comb begin
    shiftReg_d = shiftReg_q;
    bitCnt_d   = bitCnt_q;
    holdBuf_d  = holdBuf_q;
    bufFull_d  = bufFull_q;
    if (state_q == IDLE) begin
      if (accept) begin
        shiftReg_d = in_data;
        bitCnt_d   = '0;
      end
    end else begin
      if (wordDone) begin
        if (bufFull_q) begin
          shiftReg_d = holdBuf_q;
          bitCnt_d   = '0;
          bufFull_d  = 1'b0;
        end else if (accept) begin
          shiftReg_d = in_data;
          bitCnt_d   = '0;
        end else begin
          shiftReg_d = '0;
          bitCnt_d   = '0;
        end
      end else begin
        if (tx_en) begin
          shiftReg_d = {shiftReg_q[WIDTH-2:0], 1'b0};
          bitCnt_d   = bitCnt_q + 1'b1;
        end
        if (accept) begin
          holdBuf_d = in_data;
          bufFull_d = 1'b1;
        end
      end
    end
  end

  // Datapath registers; a reset drops both the partial and the buffered word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shiftReg_q <= '0;
      bitCnt_q   <= '0;
      holdBuf_q  <= '0;
      bufFull_q  <= 1'b0;
    end else begin
      shiftReg_q <= shiftReg_d;
      bitCnt_q   <= bitCnt_d;
      holdBuf_q  <= holdBuf_d;
      bufFull_q  <= bufFull_d;
    end
  end

  // Keeps in_rdy low during reset and for the first cycle after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdyEn_q <= 1'b0;
    end else begin
      rdyEn_q <= 1'b1;
    end
  end

  // Outputs come from registers only.
  always_comb begin
    in_rdy  = rdyEn_q && !bufFull_q;
    tx_val  = (state_q == SHIFT);
    tx_data = shiftReg_q[WIDTH-1];
    tx_last = (state_q == SHIFT) && lastBit;
    busy    = (state_q == SHIFT) || bufFull_q;
  end

endmodule

// File: tb/tb_par2ser.sv
// tb_par2ser: self-checking bench for par2ser (WIDTH = 32).
// Directed vector tables, hand-written multi-cycle sequences and a randomized
// run compared against a queue-based model plus a loopback receiver.
module tb_par2ser;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] inData;
  logic         inVal;
  logic         txEn;
  logic         inRdy;
  logic         txData;
  logic         txVal;
  logic         txLast;
  logic         busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic         inVal;
    logic [W-1:0] inData;
    logic         txEn;
    logic         expVal;
    logic         expData;
    logic         expLast;
    logic         expRdy;
    logic         expBusy;
  } vec_t;

  vec_t vecs[$];

  par2ser #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_data (inData),
    .in_val  (inVal),
    .in_rdy  (inRdy),
    .tx_en   (txEn),
    .tx_data (txData),
    .tx_val  (txVal),
    .tx_last (txLast),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic e);
    inVal  = v;
    inData = d;
    txEn   = e;
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic addVec(input logic v, input logic [W-1:0] d, input logic e,
                        input logic eVal, input logic eData, input logic eLast,
                        input logic eRdy, input logic eBusy);
    vec_t t;
    t.inVal = v; t.inData = d; t.txEn = e;
    t.expVal = eVal; t.expData = eData; t.expLast = eLast;
    t.expRdy = eRdy; t.expBusy = eBusy;
    vecs.push_back(t);
  endtask

  // One word from idle, optionally stalling stallLen cycles while bit stallAt shows.
  task automatic addWordVecs(input logic [W-1:0] word, input int stallAt, input int stallLen);
    addVec(1'b1, word, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < W; k++) begin
      if (k == stallAt) begin
        for (int s = 0; s < stallLen; s++) begin
          addVec(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, word[W-1-k], (k == W-1), 1'b1, 1'b1);
        end
      end
      addVec(1'b0, 32'h0BAD_F00D, 1'b1, 1'b1, word[W-1-k], (k == W-1), 1'b1, 1'b1);
    end
    addVec(1'b0, 32'h5555_AAAA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic doReset();
    rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("rstRdy", inRdy, 0);
    checkOutput("rstVal", txVal, 0);
    checkOutput("rstLast", txLast, 0);
    checkOutput("rstData", txData, 0);
    checkOutput("rstBusy", busy, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("postRstRdy", inRdy, 1);
  endtask

  initial begin
    logic [W-1:0]   w1, w2, tmp, rxWord;
    logic [2*W-1:0] got64;
    logic [W-1:0]   mq[$];
    logic [W-1:0]   sentQ[$];
    int idx, rxCnt, wordsRx, valCount, firstHigh, lastHigh, rdyLow, rdyFirstLow, extra;
    logic v, e, expRdy, expVal, acc;

    applyStimulus(1'b0, '0, 1'b0);
    doReset();

    // Directed tables: plain word, then a word with a 5-cycle stall at bit 10.
    addWordVecs(32'hA5A5_0F0F, -1, 0);
    addWordVecs(32'h8000_0001, 10, 5);
    foreach (vecs[i]) begin
      @(negedge clk);
      checkOutput("tblVal", txVal, vecs[i].expVal);
      checkOutput("tblRdy", inRdy, vecs[i].expRdy);
      checkOutput("tblBusy", busy, vecs[i].expBusy);
      if (vecs[i].expVal) begin
        checkOutput("tblData", txData, vecs[i].expData);
        checkOutput("tblLast", txLast, vecs[i].expLast);
      end
      applyStimulus(vecs[i].inVal, vecs[i].inData, vecs[i].txEn);
    end

    // Back-to-back: two words, 64 contiguous bits, in_rdy low for 31 samples.
    w1 = 32'hFFFF_0000;
    w2 = 32'h0000_FFFF;
    @(negedge clk);
    applyStimulus(1'b1, w1, 1'b1);
    valCount = 0; firstHigh = -1; lastHigh = -1; rdyLow = 0; rdyFirstLow = -1; got64 = '0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (txVal) begin
        if (firstHigh < 0) firstHigh = c;
        lastHigh = c;
        valCount++;
        got64 = {got64[2*W-2:0], txData};
      end
      if (!inRdy) begin
        if (rdyFirstLow < 0) rdyFirstLow = c;
        rdyLow++;
      end
      if (c == 0) applyStimulus(1'b1, w2, 1'b1);
      else        applyStimulus(1'b0, '0, 1'b1);
    end
    checkOutput("b2bValCount", valCount, 64);
    checkOutput("b2bFirst", firstHigh, 0);
    checkOutput("b2bContig", lastHigh - firstHigh + 1, valCount);
    checkOutput("b2bBitsHi", got64[2*W-1:W], w1);
    checkOutput("b2bBitsLo", got64[W-1:0], w2);
    checkOutput("b2bRdyLow", rdyLow, 31);
    checkOutput("b2bRdyFirstLow", rdyFirstLow, 1);
    checkOutput("b2bBusyEnd", busy, 0);

    // Reset mid-word at bit 17 with a second word buffered.
    w1 = 32'h1234_5678;
    @(negedge clk);
    applyStimulus(1'b1, w1, 1'b1);
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      checkOutput("rmwData", txData, w1[W-1-c]);
      if (c == 0) applyStimulus(1'b1, 32'hCAFE_BABE, 1'b1);
      else        applyStimulus(1'b0, '0, 1'b1);
    end
    @(negedge clk);
    checkOutput("rmwBuffered", inRdy, 0);
    #2 rst = 1'b0;
    #1;
    checkOutput("rmwVal", txVal, 0);
    checkOutput("rmwBusy", busy, 0);
    checkOutput("rmwRdyInRst", inRdy, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rmwRdyAfter", inRdy, 1);
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (txVal || busy) extra++;
    end
    checkOutput("rmwNoMoreBits", extra, 0);

    // Randomized run against a word-queue model with a loopback receiver.
    doReset();
    idx = 0; rxCnt = 0; wordsRx = 0; rxWord = '0;
    for (int cyc = 0; cyc < 20000 && wordsRx < 100; cyc++) begin
      @(negedge clk);
      expRdy = (mq.size() < 2);
      expVal = (mq.size() > 0);
      checkOutput("rndRdy", inRdy, expRdy);
      checkOutput("rndVal", txVal, expVal);
      checkOutput("rndBusy", busy, expVal);
      if (expVal) begin
        tmp = mq[0];
        checkOutput("rndData", txData, tmp[W-1-idx]);
        checkOutput("rndLast", txLast, (idx == W-1));
      end
      v = ($urandom_range(0, 99) < 60);
      e = ($urandom_range(0, 99) < 80);
      applyStimulus(v, $urandom, e);
      if (txVal && e) begin
        rxWord = {rxWord[W-2:0], txData};
        rxCnt++;
        if (rxCnt == W) begin
          rxCnt = 0;
          wordsRx++;
          if (sentQ.size() == 0) begin
            checkOutput("loopNoWord", 1, 0);
          end else begin
            checkOutput("loopWord", rxWord, sentQ.pop_front());
          end
        end
      end
      acc = v && expRdy;
      if (mq.size() > 0 && e) begin
        idx++;
        if (idx == W) begin
          void'(mq.pop_front());
          idx = 0;
        end
      end
      if (acc) begin
        mq.push_back(inData);
        sentQ.push_back(inData);
      end
    end
    if (wordsRx < 100) checkOutput("rndTimeout", wordsRx, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
